// File: rtl/uart_rx_pkt_ctrl.sv
// Packet framer behind the UART receiver: SOF, LEN, payload, XOR checksum.
// A validated payload is held in a local buffer until the consumer acks it.
module uart_rx_pkt_ctrl #(
  parameter int          ADDR_W        = 4,
  parameter logic [7:0]  SOF           = 8'hA5,
  parameter int          TIMEOUT_TICKS = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              b_tick,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic              pkt_valid,
  output logic [ADDR_W:0]   pkt_len,
  input  logic [ADDR_W-1:0] pkt_rd_addr,
  output logic [7:0]        pkt_rd_data,
  input  logic              pkt_ack,
  output logic              err_chk,
  output logic              err_len,
  output logic              err_timeout,
  output logic              err_ovr,
  output logic [2:0]        state_dbg
);

  localparam int               MAX_LEN   = 2**ADDR_W;
  localparam int               TO_W      = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CHK     = 3'd3,
    HOLD    = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   cnt;
  logic [7:0]        chk;
  logic [TO_W-1:0]   to_cnt;
  logic [7:0]        pay_mem [MAX_LEN];
  logic              buf_we;

  assign state_dbg = state;

  // Handshake: pkt_valid rises after a good checksum and stays high with
  // pkt_len/pkt_rd_data stable until a cycle with pkt_ack=1; pkt_valid drops
  // on the next cycle. pkt_ack while pkt_valid=0 has no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pkt_valid   <= 1'b0;
      pkt_len     <= '0;
      len_q       <= '0;
      cnt         <= '0;
      chk         <= '0;
      to_cnt      <= '0;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_ovr     <= 1'b0;
    end else begin
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_ovr     <= 1'b0;
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (rx_done && rx_data == SOF) state <= LEN;
        end
        LEN, PAYLOAD, CHK: begin
          if (rx_done) begin
            // A byte on the expiring tick still counts: rx_done wins.
            to_cnt <= '0;
            case (state)
              LEN: begin
                if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                  err_len <= 1'b1;
                  state   <= IDLE;
                end else begin
                  len_q <= rx_data[ADDR_W:0];
                  chk   <= rx_data;
                  cnt   <= '0;
                  state <= PAYLOAD;
                end
              end
              PAYLOAD: begin
                chk <= chk ^ rx_data;
                cnt <= cnt + 1'b1;
                if (cnt == len_q - 1'b1) state <= CHK;
              end
              default: begin
                if (rx_data == chk) begin
                  pkt_valid <= 1'b1;
                  pkt_len   <= len_q;
                  state     <= HOLD;
                end else begin
                  err_chk <= 1'b1;
                  state   <= IDLE;
                end
              end
            endcase
          end else if (b_tick) begin
            if (to_cnt == TO_LAST) begin
              err_timeout <= 1'b1;
              to_cnt      <= '0;
              state       <= IDLE;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          to_cnt <= '0;
          if (pkt_ack) begin
            pkt_valid <= 1'b0;
            pkt_len   <= '0;
            state     <= (rx_done && rx_data == SOF) ? LEN : IDLE;
          end else if (rx_done) begin
            err_ovr <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Buffer is only written while collecting payload, so a held packet is safe.
  assign buf_we = !rst && state == PAYLOAD && rx_done;

  always_ff @(posedge clk) begin
    if (buf_we) pay_mem[cnt[ADDR_W-1:0]] <= rx_data;
  end

  assign pkt_rd_data = pay_mem[pkt_rd_addr];

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench for uart_rx_pkt_ctrl: byte tables with expected outputs plus
// hand-written sequences for timeout, overrun, ack race and reset.
module tb_uart_rx_pkt_ctrl;

  localparam int ADDR_W = 4;
  localparam logic [2:0] S_IDLE = 3'd0, S_LEN = 3'd1, S_PAYLOAD = 3'd2, S_CHK = 3'd3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              b_tick = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_done = 1'b0;
  logic              pkt_valid;
  logic [ADDR_W:0]   pkt_len;
  logic [ADDR_W-1:0] pkt_rd_addr = '0;
  logic [7:0]        pkt_rd_data;
  logic              pkt_ack = 1'b0;
  logic              err_chk, err_len, err_timeout, err_ovr;
  logic [2:0]        state_dbg;

  uart_rx_pkt_ctrl #(.ADDR_W(ADDR_W), .SOF(8'hA5), .TIMEOUT_TICKS(480)) dut (
    .clk(clk), .rst(rst), .b_tick(b_tick), .rx_data(rx_data), .rx_done(rx_done),
    .pkt_valid(pkt_valid), .pkt_len(pkt_len), .pkt_rd_addr(pkt_rd_addr),
    .pkt_rd_data(pkt_rd_data), .pkt_ack(pkt_ack), .err_chk(err_chk),
    .err_len(err_len), .err_timeout(err_timeout), .err_ovr(err_ovr),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // error pulse monitor: counts high cycles, so a stretched pulse shows up
  int n_chk = 0, n_len = 0, n_to = 0, n_ovr = 0, n_multi = 0;
  always @(negedge clk) begin
    if (!rst) begin
      n_chk   += int'(err_chk);
      n_len   += int'(err_len);
      n_to    += int'(err_timeout);
      n_ovr   += int'(err_ovr);
      if ((int'(err_chk) + int'(err_len) + int'(err_timeout) + int'(err_ovr)) > 1) n_multi++;
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       exp_valid;
    logic [3:0] exp_err;   // {chk, len, timeout, ovr}
  } vec_t;

  vec_t tv[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      b_tick = 1'b1;
      @(negedge clk);
      b_tick = 1'b0;
    end
  endtask

  task automatic do_ack();
    @(negedge clk);
    pkt_ack = 1'b1;
    @(negedge clk);
    pkt_ack = 1'b0;
    check("valid_after_ack", {31'd0, pkt_valid}, 32'd0);
  endtask

  task automatic check_rd(input logic [ADDR_W-1:0] a, input logic [7:0] exp);
    pkt_rd_addr = a;
    #1;
    check($sformatf("rd_data[%0d]", a), {24'd0, pkt_rd_data}, {24'd0, exp});
  endtask

  task automatic add(input logic [7:0] d, input logic v, input logic [3:0] e);
    vec_t x;
    x.data = d;
    x.exp_valid = v;
    x.exp_err = e;
    tv.push_back(x);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tv.size(); i++) begin
      send_byte(tv[i].data);
      check($sformatf("%s[%0d].valid", tag, i), {31'd0, pkt_valid}, {31'd0, tv[i].exp_valid});
      check($sformatf("%s[%0d].err", tag, i),
            {28'd0, err_chk, err_len, err_timeout, err_ovr}, {28'd0, tv[i].exp_err});
    end
    tv.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
    check("reset_valid", {31'd0, pkt_valid}, 32'd0);
    check("reset_len", {27'd0, pkt_len}, 32'd0);
    check("reset_err", {28'd0, err_chk, err_len, err_timeout, err_ovr}, 32'd0);
    rst = 1'b0;

    // good frame, checksum 03^11^22^33 = 03
    add(8'hA5, 0, 0); add(8'h03, 0, 0); add(8'h11, 0, 0); add(8'h22, 0, 0);
    add(8'h33, 0, 0); add(8'h03, 1, 0);
    run_table("good");
    check("good_len", {27'd0, pkt_len}, 32'd3);
    check_rd(0, 8'h11); check_rd(1, 8'h22); check_rd(2, 8'h33);
    do_ack();

    // bad checksum (expected 13), LEN 0, LEN 17, then a good 1-byte frame
    add(8'hA5, 0, 0); add(8'h02, 0, 0); add(8'hAA, 0, 0); add(8'hBB, 0, 0);
    add(8'h00, 0, 4'b1000);
    add(8'hA5, 0, 0); add(8'h00, 0, 4'b0100);
    add(8'hA5, 0, 0); add(8'h11, 0, 4'b0100);
    add(8'hA5, 0, 0); add(8'h01, 0, 0); add(8'h5C, 0, 0); add(8'h5D, 1, 0);
    run_table("errs");
    check("short_len", {27'd0, pkt_len}, 32'd1);
    check_rd(0, 8'h5C);
    do_ack();

    // junk then maximum length frame, checksum 10 ^ (xor 00..0F) = 10
    add(8'h00, 0, 0); add(8'hFF, 0, 0); add(8'h7E, 0, 0);
    add(8'hA5, 0, 0); add(8'h10, 0, 0);
    for (int i = 0; i < 16; i++) add(8'(i), 0, 0);
    add(8'h10, 1, 0);
    run_table("max");
    check("max_len", {27'd0, pkt_len}, 32'd16);
    check_rd(15, 8'h0F); check_rd(0, 8'h00); check_rd(7, 8'h07);
    do_ack();

    // inter-byte timeout in PAYLOAD
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    tick_n(479);
    check("to_not_yet", {31'd0, err_timeout}, 32'd0);
    check("to_state_before", {29'd0, state_dbg}, {29'd0, S_PAYLOAD});
    tick_n(1);
    check("to_pulse", {31'd0, err_timeout}, 32'd1);
    check("to_state_after", {29'd0, state_dbg}, {29'd0, S_IDLE});
    add(8'hA5, 0, 0); add(8'h01, 0, 0); add(8'h42, 0, 0); add(8'h43, 1, 0);
    run_table("after_to");
    check_rd(0, 8'h42);
    do_ack();

    // rx_done on the expiring tick: byte wins
    send_byte(8'hA5); send_byte(8'h01);
    tick_n(479);
    @(negedge clk);
    b_tick = 1'b1; rx_done = 1'b1; rx_data = 8'h42;
    @(negedge clk);
    b_tick = 1'b0; rx_done = 1'b0;
    check("race_no_to", {31'd0, err_timeout}, 32'd0);
    check("race_state", {29'd0, state_dbg}, {29'd0, S_CHK});
    send_byte(8'h43);
    check("race_valid", {31'd0, pkt_valid}, 32'd1);
    check_rd(0, 8'h42);
    do_ack();

    // overrun while held, then ack coincident with SOF
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h5C); send_byte(8'h5D);
    check("hold_valid", {31'd0, pkt_valid}, 32'd1);
    send_byte(8'h00);
    check("ovr_pulse", {31'd0, err_ovr}, 32'd1);
    check("ovr_valid", {31'd0, pkt_valid}, 32'd1);
    check("ovr_len", {27'd0, pkt_len}, 32'd1);
    check_rd(0, 8'h5C);
    @(negedge clk);
    pkt_ack = 1'b1; rx_done = 1'b1; rx_data = 8'hA5;
    @(negedge clk);
    pkt_ack = 1'b0; rx_done = 1'b0;
    check("ackrace_valid", {31'd0, pkt_valid}, 32'd0);
    check("ackrace_state", {29'd0, state_dbg}, {29'd0, S_LEN});
    add(8'h01, 0, 0); add(8'h07, 0, 0); add(8'h06, 1, 0);
    run_table("ackrace");
    check("ackrace_len", {27'd0, pkt_len}, 32'd1);
    check_rd(0, 8'h07);
    do_ack();

    // reset mid-frame
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rst_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
    check("rst_valid", {31'd0, pkt_valid}, 32'd0);
    check("rst_err", {28'd0, err_chk, err_len, err_timeout, err_ovr}, 32'd0);
    add(8'hA5, 0, 0); add(8'h01, 0, 0); add(8'h5C, 0, 0); add(8'h5D, 1, 0);
    run_table("after_rst");
    check_rd(0, 8'h5C);
    do_ack();

    repeat (2) @(negedge clk);
    check("cnt_err_chk", n_chk, 32'd1);
    check("cnt_err_len", n_len, 32'd2);
    check("cnt_err_timeout", n_to, 32'd1);
    check("cnt_err_ovr", n_ovr, 32'd1);
    check("cnt_err_multi", n_multi, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_pkt_ctrl.md
Name: uart_rx_pkt_ctrl

Overview:
Frame controller placed directly after the UART receiver. It consumes the received byte stream (rx_data / rx_done / b_tick) and sequences it through a fixed packet format: SOF, LEN, payload, XOR checksum. A validated payload is held in an internal buffer and presented to a consumer through a valid/ack handshake. The block also flags framing errors, checksum errors, inter-byte timeouts and overruns.

Parameters:
ADDR_W, 4, payload buffer address width; MAX_LEN = 2**ADDR_W bytes (16)
SOF, 8'hA5, start-of-frame byte
TIMEOUT_TICKS, 480, b_tick count allowed between bytes inside a frame (3 byte times at 16x oversampling)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
b_tick  input  1  16x oversample baud tick from the baud generator
rx_data  input  8  received byte, valid when rx_done=1
rx_done  input  1  one-cycle pulse: byte received
pkt_valid  output  1  buffered packet available; held until pkt_ack
pkt_len  output  ADDR_W+1  payload length of the held packet, 1..MAX_LEN
pkt_rd_addr  input  ADDR_W  payload read address
pkt_rd_data  output  8  payload byte at pkt_rd_addr, combinational read
pkt_ack  input  1  consumer releases the packet; ignored when pkt_valid=0
err_chk  output  1  one-cycle pulse: checksum mismatch
err_len  output  1  one-cycle pulse: LEN=0 or LEN>MAX_LEN
err_timeout  output  1  one-cycle pulse: inter-byte timeout
err_ovr  output  1  one-cycle pulse: byte dropped while a packet was held

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE; pkt_valid, pkt_len, all err_* = 0; byte counter, checksum and timeout counter = 0. Buffer contents are not reset.
- Reset asserted mid-frame or while a packet is held: the partial frame or held packet is discarded. Normal operation resumes the cycle after rst deasserts.
- Bytes are accepted only on cycles with rx_done=1. The FSM evaluates rx_data on that cycle.
- States and transitions:
  - IDLE: on a byte equal to SOF, go to LEN. Any other byte is discarded silently, with no error.
  - LEN: on a byte, if it is 0 or greater than MAX_LEN, pulse err_len and go to IDLE. Otherwise latch len, set chk=byte, set cnt=0, go to PAYLOAD.
  - PAYLOAD: on a byte, write buf[cnt]=byte, chk^=byte, cnt++. When cnt reaches len-1 on this write, go to CHK.
  - CHK: on a byte equal to chk, go to HOLD with pkt_valid=1 the next cycle. On a mismatch, pulse err_chk and go to IDLE. The buffer is not exposed in either case.
  - HOLD: pkt_valid=1 and pkt_len=len, stable. pkt_ack=1 leaves HOLD, and pkt_valid=0 the following cycle.
- HOLD byte handling:
  - A byte arriving in HOLD without pkt_ack: dropped, err_ovr pulses.
  - A byte arriving in the same cycle as pkt_ack: processed as an IDLE byte. If it is SOF, the next state is LEN.
- Latency: pkt_valid rises exactly one cycle after the rx_done of a correct checksum byte. Every err_* rises one cycle after its causing event and lasts exactly one cycle.
- Timeout (states LEN, PAYLOAD, CHK only):
  - The counter increments on b_tick and clears on rx_done.
  - If a b_tick arrives while the counter equals TIMEOUT_TICKS-1, pulse err_timeout and go to IDLE.
  - rx_done in the same cycle as the expiring tick: rx_done wins and the byte is processed normally.
  - The counter is held at 0 in IDLE and HOLD.
- Width and arithmetic: cnt is ADDR_W+1 bits so that len=MAX_LEN does not wrap. The checksum is 8-bit XOR over the LEN byte and all payload bytes; SOF is excluded.
- Read port: pkt_rd_data = buf[pkt_rd_addr] at all times. It is meaningful only while pkt_valid=1 and pkt_rd_addr<pkt_len.
- At most one err_* pulses per cycle.

Test Plan:
- Good frame: bytes A5 03 11 22 33 03 -> pkt_valid=1 one cycle after the last rx_done; pkt_len=3; rd_addr 0/1/2 return 11/22/33. Assert pkt_ack -> pkt_valid=0 next cycle.
- Bad checksum and bad length: A5 02 AA BB 00 -> err_chk pulse, no pkt_valid. A5 00 -> err_len pulse. A5 11 (17 > 16) -> err_len pulse. Then A5 01 5C 5D -> pkt_len=1, data 5C.
- Max length and junk: 3 junk bytes 00 FF 7E, then A5 10 followed by 16 bytes 00..0F and chk = 10^(XOR 00..0F) = 10 -> accepted; pkt_len=16, rd_addr 15 returns 0F.
- Timeout: A5 02 11, then 480 b_ticks without rx_done -> err_timeout on the 480th tick and state IDLE. The following A5 01 42 43 is accepted.
- Timeout race: rx_done coincident with the 480th tick -> no err_timeout, and the frame completes.
- Overrun and ack race: hold a packet without ack, send 00 -> err_ovr pulse and held data unchanged. Then pkt_ack in the same cycle as an A5 byte, followed by 01 07 06 -> a second packet is accepted with len=1, data 07.
- Reset mid-frame: assert rst after A5 03 11 -> no pkt_valid and all err_* = 0. A new good frame is accepted afterwards.
